// File: rtl/fht_a20_decoder_pkg.sv
// rtl/fht_a20_decoder_pkg.sv - shared constants, FSM state type and mask helper for the (20,A) FHT decoder
//
// Package block_code_pkg
//   NUM_SYM     : symbols per transform word (32)
//   FHT_STAGES  : butterfly layers per transform (5)
//   A_MAX       : largest supported code_length (11 with FHT_A20_MASK_SEARCH_EN, else 6)
//   fsm_state_t : decoder control states
//   A20_MASK    : basis columns 6..10 of the (20,A) code in permuted symbol order,
//                 positions 20..31 are always zero
//   hyp_mask()  : combined mask word for a hypothesis index
package block_code_pkg;

  localparam int NUM_SYM    = 32;
  localparam int FHT_STAGES = 5;

`ifdef FHT_A20_MASK_SEARCH_EN
  localparam int A_MAX = 11;
`else
  localparam int A_MAX = 6;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_MASK,
    S_FHT,
    S_SEARCH,
    S_DONE
  } fsm_state_t;

  // Index j holds basis column 6+j.
  localparam logic [4:0][31:0] A20_MASK = {
    32'h0003_7A4D,
    32'h0009_B1D6,
    32'h000E_2C5B,
    32'h0006_D3A5,
    32'h000B_5E68
  };

  // Hypothesis h selects the XOR of mask words j for every set bit j of h.
  function automatic logic [31:0] hyp_mask(input logic [4:0] h);
    logic [31:0] m;
    m = 32'd0;
    for (int j = 0; j < 5; j++) begin
      if (h[j]) m = m ^ A20_MASK[j];
    end
    return m;
  endfunction

endpackage

// File: rtl/fht_butterfly_layer.sv
// rtl/fht_butterfly_layer.sv - one combinational radix-2 layer of a 32-point Hadamard transform
//
// Ports
//   stage : layer index 0..4, pairs element i with element i + 2^stage
//   din   : 32 signed W-bit inputs
//   dout  : 32 signed W-bit outputs, (a+b) at the lower index, (a-b) at the upper
module fht_butterfly_layer
  import block_code_pkg::*;
#(
  parameter int W = 9
) (
  input  logic [2:0]          stage,
  input  logic signed [W-1:0] din  [NUM_SYM],
  output logic signed [W-1:0] dout [NUM_SYM]
);

  logic [4:0] stride;

  always_comb begin
    stride = 5'd1 << stage;
    for (int i = 0; i < NUM_SYM; i++) begin
      // The lower element of a pair has the stride bit clear; its partner is found by toggling it.
      if ((5'(i) & stride) == 5'd0) begin
        dout[i] = din[i] + din[5'(i) ^ stride];
      end else begin
        dout[i] = din[5'(i) ^ stride] - din[i];
      end
    end
  end

endmodule

// File: rtl/fht_a20_decoder.sv
// rtl/fht_a20_decoder.sv - soft-decision ML decoder for the (20,A) block code using a 32-point FHT
//
// Optional feature macro: FHT_A20_MASK_SEARCH_EN (mask hypothesis loop, A up to 11)
//
// Ports
//   clk, rst      : rising-edge clock, synchronous active-high reset
//   in_symbols    : 32 permuted signed soft symbols, element i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_valid      : in_symbols / code_length valid
//   in_ready      : block idle, a word is accepted this cycle if in_valid
//   code_length   : A, number of information bits
//   out_bits      : decoded bits, bits at and above A are zero
//   out_metric    : |correlation| of the winning candidate
//   out_err       : unsupported code_length
//   out_valid     : single-cycle pulse qualifying out_*
module fht_a20_decoder
  import block_code_pkg::*;
#(
  parameter int DATA_WIDTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [32*DATA_WIDTH-1:0]    in_symbols,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [3:0]                  code_length,
  output logic [12:0]                 out_bits,
  output logic [DATA_WIDTH+4:0]       out_metric,
  output logic                        out_err,
  output logic                        out_valid
);

  localparam int W = DATA_WIDTH + 5;

  fsm_state_t state;

  logic signed [DATA_WIDTH-1:0] sym_r    [NUM_SYM];
  logic signed [W-1:0]          work     [NUM_SYM];
  logic signed [W-1:0]          masked   [NUM_SYM];
  logic signed [W-1:0]          bfly_out [NUM_SYM];

  logic [3:0]   a_r;
  logic         err_r;
  logic [2:0]   stage_r;
  logic [4:0]   idx_r;
  logic [W-1:0] best_mag;
  logic [4:0]   best_idx;
  logic         best_neg;
  logic [4:0]   hyp_bits;
  logic [31:0]  mask_word;

`ifdef FHT_A20_MASK_SEARCH_EN
  logic [4:0] hyp_r;
  logic [4:0] best_hyp;
  logic [4:0] hyp_last;
  assign hyp_bits = best_hyp;
  // For A>6 there are 2^(A-6) hypotheses; A=11 wraps 1<<5 to 0 so the -1 yields 31.
  assign hyp_last = (a_r > 4'd6) ? ((5'd1 << (a_r - 4'd6)) - 5'd1) : 5'd0;
`else
  assign hyp_bits = 5'd0;
`endif

  assign in_ready = (state == S_IDLE);

  logic len_ok;
  assign len_ok = (code_length != 4'd0) && (code_length <= 4'(A_MAX));

  // Sign-extend each symbol and negate it wherever the current hypothesis mask has a one.
  always_comb begin
    mask_word = 32'd0;
`ifdef FHT_A20_MASK_SEARCH_EN
    mask_word = hyp_mask(hyp_r);
`endif
    for (int i = 0; i < NUM_SYM; i++) begin
      masked[i] = $signed({{5{sym_r[i][DATA_WIDTH-1]}}, sym_r[i]});
      if (mask_word[i]) masked[i] = -masked[i];
    end
  end

  fht_butterfly_layer #(.W(W)) u_bfly (
    .stage (stage_r),
    .din   (work),
    .dout  (bfly_out)
  );

  logic signed [W-1:0] y;
  logic [W-1:0]        y_mag;
  logic                idx_allowed;
  logic [12:0]         bits_raw;
  logic [12:0]         bits_mask;

  always_comb begin
    y     = work[idx_r];
    // Unsigned view of the magnitude; the most negative value maps onto 2^(W-1) correctly.
    y_mag = y[W-1] ? W'(-y) : W'(y);
    // For short codes only the first 2^(A-1) transform outputs are codewords.
    idx_allowed = (a_r > 4'd6) || ({1'b0, idx_r} < (6'd1 << (a_r - 4'd1)));
    bits_raw  = {2'b00, hyp_bits, best_idx, best_neg};
    bits_mask = (13'd1 << a_r) - 13'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      out_valid  <= 1'b0;
      out_err    <= 1'b0;
      out_bits   <= 13'd0;
      out_metric <= '0;
      err_r      <= 1'b0;
      a_r        <= 4'd0;
      stage_r    <= 3'd0;
      idx_r      <= 5'd0;
      best_mag   <= '0;
      best_idx   <= 5'd0;
      best_neg   <= 1'b0;
`ifdef FHT_A20_MASK_SEARCH_EN
      hyp_r      <= 5'd0;
      best_hyp   <= 5'd0;
`endif
    end else begin
      out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < NUM_SYM; i++) begin
              sym_r[i] <= in_symbols[i*DATA_WIDTH +: DATA_WIDTH];
            end
            a_r      <= code_length;
            best_mag <= '0;
            best_idx <= 5'd0;
            best_neg <= 1'b0;
`ifdef FHT_A20_MASK_SEARCH_EN
            hyp_r    <= 5'd0;
            best_hyp <= 5'd0;
`endif
            err_r    <= !len_ok;
            state    <= len_ok ? S_MASK : S_DONE;
          end
        end
        S_MASK: begin
          for (int i = 0; i < NUM_SYM; i++) work[i] <= masked[i];
          stage_r <= 3'd0;
          state   <= S_FHT;
        end
        S_FHT: begin
          for (int i = 0; i < NUM_SYM; i++) work[i] <= bfly_out[i];
          stage_r <= stage_r + 3'd1;
          if (stage_r == 3'(FHT_STAGES - 1)) begin
            idx_r <= 5'd0;
            state <= S_SEARCH;
          end
        end
        S_SEARCH: begin
          // Strict compare: ties keep the earlier hypothesis and index.
          if (idx_allowed && (y_mag > best_mag)) begin
            best_mag <= y_mag;
            best_idx <= idx_r;
            best_neg <= y[W-1];
`ifdef FHT_A20_MASK_SEARCH_EN
            best_hyp <= hyp_r;
`endif
          end
          idx_r <= idx_r + 5'd1;
          if (idx_r == 5'd31) begin
`ifdef FHT_A20_MASK_SEARCH_EN
            if (hyp_r != hyp_last) begin
              hyp_r <= hyp_r + 5'd1;
              state <= S_MASK;
            end else begin
              state <= S_DONE;
            end
`else
            state <= S_DONE;
`endif
          end
        end
        S_DONE: begin
          out_valid  <= 1'b1;
          out_err    <= err_r;
          out_bits   <= err_r ? 13'd0 : (bits_raw & bits_mask);
          out_metric <= err_r ? '0 : best_mag;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
